// File: rtl/regfile_pkg.sv
// Shared constants for the register file with scoreboard.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending producer and keeps a
// registered count of busy registers.
// Ports:
//   clk, rst            - clock, async active-high reset
//   wr_en, destadd      - completing write (clears busy bit)
//   rsv_en, rsv_add     - reservation (sets busy bit)
//   srcadd1, srcadd2    - lookup addresses
//   src1_busy/src2_busy - busy status of the looked-up registers (combinational)
//   busy_cnt            - number of busy registers (registered)
// Macro REGFILE_ZERO_REG_EN: register 0 can never be reserved or busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] destadd,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_add,
  input  logic [ADDR_W-1:0] srcadd1,
  input  logic [ADDR_W-1:0] srcadd2,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsv_ok;
  logic             inc;
  logic             dec;

  // Next busy vector and count; a reserve of the register being written wins.
  always_comb begin
    rsv_ok = rsv_en;
`ifdef REGFILE_ZERO_REG_EN
    rsv_ok = rsv_en && (rsv_add != '0);
`endif
    busy_d = busy_q;
    if (wr_en)  busy_d[destadd] = 1'b0;
    if (rsv_ok) busy_d[rsv_add] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
    // Count only real bit transitions, judged against the pre-edge state.
    inc = rsv_ok && !busy_q[rsv_add];
    dec = wr_en && busy_q[destadd] && !(rsv_ok && (rsv_add == destadd));
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_W'(DEPTH))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A same-cycle write to the looked-up register resolves its pending status.
  always_comb begin
    src1_busy = busy_q[srcadd1] && !(wr_en && (destadd == srcadd1)) && !rst;
    src2_busy = busy_q[srcadd2] && !(wr_en && (destadd == srcadd2)) && !rst;
  end

  assign busy_cnt = cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-through bypass and a busy
// scoreboard for pending producers.
// Ports:
//   clk, rst            - clock, async active-high reset
//   srcadd1, srcadd2    - read addresses
//   destadd, wr_en      - write address / strobe
//   ALUout              - write data
//   rsv_en, rsv_add     - reserve strobe / register
//   src1, src2          - read data (combinational, bypassed)
//   src1_busy/src2_busy - read register has pending write
//   busy_cnt            - number of busy registers
// Macro REGFILE_ZERO_REG_EN: register 0 reads zero and ignores writes/reserves.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcadd1,
  input  logic [ADDR_W-1:0] srcadd2,
  input  logic [ADDR_W-1:0] destadd,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] ALUout,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_add,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_ok;
  logic              rsv_ok;

  // Effective write/reserve strobes; nothing takes effect while in reset.
  always_comb begin
    wr_ok  = wr_en && !rst;
    rsv_ok = rsv_en && !rst;
`ifdef REGFILE_ZERO_REG_EN
    wr_ok  = wr_en && !rst && (destadd != '0);
`endif
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[destadd] = ALUout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-through bypass.
  always_comb begin
    src1 = regs_q[srcadd1];
    src2 = regs_q[srcadd2];
    if (wr_ok && (destadd == srcadd1)) src1 = ALUout;
    if (wr_ok && (destadd == srcadd2)) src2 = ALUout;
`ifdef REGFILE_ZERO_REG_EN
    if (srcadd1 == '0) src1 = '0;
    if (srcadd2 == '0) src2 = '0;
`endif
    if (rst) begin
      src1 = '0;
      src2 = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_ok),
    .destadd   (destadd),
    .rsv_en    (rsv_ok),
    .rsv_add   (rsv_add),
    .srcadd1   (srcadd1),
    .srcadd2   (srcadd2),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .busy_cnt  (busy_cnt)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs computed
// from an array-based reference model; a negedge monitor pops and compares.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  srcadd1, srcadd2, destadd, rsv_add;
  logic        wr_en, rsv_en;
  logic [31:0] ALUout;
  logic [31:0] src1, src2;
  logic        src1_busy, src2_busy;
  logic [5:0]  busy_cnt;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .srcadd1   (srcadd1),
    .srcadd2   (srcadd2),
    .destadd   (destadd),
    .wr_en     (wr_en),
    .ALUout    (ALUout),
    .rsv_en    (rsv_en),
    .rsv_add   (rsv_add),
    .src1      (src1),
    .src2      (src2),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model state
  logic [31:0] mem  [32];
  bit          busy [32];

  function automatic bit is_zero_reg(input logic [4:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return (a == 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (is_zero_reg(a)) return 32'h0;
    return mem[a];
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (busy[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'h0;
      busy[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, queue the expected pre-edge outputs, then
  // advance the model by the coming rising edge.
  task automatic drive(input logic r, input logic w, input logic [4:0] d,
                       input logic [31:0] data, input logic rv,
                       input logic [4:0] ra, input logic [4:0] s1,
                       input logic [4:0] s2, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr_en = w; destadd = d; ALUout = data;
    rsv_en = rv; rsv_add = ra; srcadd1 = s1; srcadd2 = s2;
    if (r) begin
      model_clear();
      e = '0;
    end else begin
      e.s1  = (w && d == s1 && !is_zero_reg(s1)) ? data : model_read(s1);
      e.s2  = (w && d == s2 && !is_zero_reg(s2)) ? data : model_read(s2);
      e.b1  = busy[s1] && !(w && d == s1);
      e.b2  = busy[s2] && !(w && d == s2);
      e.cnt = 6'(model_count());
      if (w && !is_zero_reg(d)) mem[d] = data;
      if (w) busy[d] = 1'b0;
      if (rv && !is_zero_reg(ra)) busy[ra] = 1'b1;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".src1"},      src1,              e.s1);
      chk({nm, ".src2"},      src2,              e.s2);
      chk({nm, ".src1_busy"}, 32'(src1_busy),    32'(e.b1));
      chk({nm, ".src2_busy"}, 32'(src2_busy),    32'(e.b2));
      chk({nm, ".busy_cnt"},  32'(busy_cnt),     32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; destadd = '0; ALUout = '0;
    rsv_en = 1'b0; rsv_add = '0; srcadd1 = '0; srcadd2 = '0;
    model_clear();

    // Reset state, with write/reserve attempts that must be blocked
    drive(1, 1, 5'd4, 32'hDEADBEEF, 1, 5'd4, 5'd4, 5'd4, "reset_hold");
    drive(1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd0, "reset_hold2");
    drive(0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd9, "post_reset");

    // Fill all registers, then read 6 and 28
    for (int k = 0; k < 32; k++)
      drive(0, 1, 5'(k), 32'hAEAEAE00 + 32'(k), 0, 5'd0, 5'(k), 5'(k ^ 1), "fill");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd6, 5'd28, "read_6_28");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd31, "read_0_31");

    // Bypass on port 2, same address on both ports
    drive(0, 1, 5'd1, 32'h44444444, 0, 5'd0, 5'd2, 5'd1, "bypass");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd1, "same_addr");

    // Reserve 3 and 5, observe, then write 3
    drive(0, 0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd5, "rsv3");
    drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd3, 5'd5, "rsv5");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd5, "busy_2");
    drive(0, 1, 5'd3, 32'h12345678, 0, 5'd0, 5'd3, 5'd5, "write3");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd5, "busy_1");

    // Collision: register 7 busy, reserve and write it in the same cycle
    drive(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd5, "rsv7");
    drive(0, 1, 5'd7, 32'h77777777, 1, 5'd7, 5'd7, 5'd5, "collide7");
    drive(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd3, "rsv7_again");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd8, "after_collide");

    // Write to a non-busy register leaves the count alone
    drive(0, 1, 5'd8, 32'h88888888, 0, 5'd0, 5'd8, 5'd7, "write_idle");

    // Bring count to 4, then reset between edges
    drive(0, 0, 5'd0, 32'h0, 1, 5'd9,  5'd9, 5'd7, "rsv9");
    drive(0, 0, 5'd0, 32'h0, 1, 5'd10, 5'd9, 5'd10, "rsv10");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0,  5'd9, 5'd10, "busy_4");
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0,  5'd6, 5'd28, "mid_reset");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0,  5'd6, 5'd9, "after_reset");

    // Register 0: write and reserve
    drive(0, 1, 5'd0, 32'h33333333, 0, 5'd0, 5'd0, 5'd0, "zero_write");
    drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd1, "zero_rsv");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, "zero_read");

    // Reserve everything, then one more: count must saturate at the depth
    for (int k = 0; k < 32; k++)
      drive(0, 0, 5'd0, 32'h0, 1, 5'(k), 5'(k), 5'(31 - k), "rsv_all");
    drive(0, 0, 5'd0, 32'h0, 1, 5'd12, 5'd12, 5'd0, "rsv_full");
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0,  5'd12, 5'd0, "full");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  d, ra, s1, s2;
      logic        w, rv, r;
      d  = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      s1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      s2 = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom_range(0, 31));
      w  = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 59) == 0);
      drive(r, w, d, $urandom, rv, ra, s1, s2, "random");
    end

    // Drain the scoreboard
    @(posedge clk);
    #1;
    wr_en = 1'b0; rsv_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports srcadd1, srcadd2  input  ADDR_W  read addresses.
REQ-006 SHALL have port destadd  input  ADDR_W  write address.
REQ-007 SHALL have port wr_en  input  1  write strobe.
REQ-008 SHALL have port ALUout  input  DATA_W  write data.
REQ-009 SHALL have port rsv_en  input  1  reserve strobe, marks a register busy (pending producer).
REQ-010 SHALL have port rsv_add  input  ADDR_W  register to reserve.
REQ-011 SHALL have ports src1, src2  output  DATA_W  read data.
REQ-012 SHALL have ports src1_busy, src2_busy  output  1  read register has pending write.
REQ-013 SHALL have port busy_cnt  output  ADDR_W+1  number of busy registers.

Function
REQ-014 SHALL write ALUout into register destadd on rising clk when wr_en=1.
REQ-015 SHALL drive srcN combinationally: ALUout if wr_en=1 and destadd==srcaddN (write-through bypass), else stored value.
REQ-016 SHALL support srcadd1==srcadd2; both ports return identical data.
REQ-017 SHALL set busy[rsv_add] on rising clk when rsv_en=1.
REQ-018 SHALL clear busy[destadd] on rising clk when wr_en=1, unless rsv_en=1 with rsv_add==destadd, in which case busy stays set (new producer wins).
REQ-019 SHALL drive srcN_busy = busy[srcaddN] AND NOT (wr_en AND destadd==srcaddN).
REQ-020 SHALL update busy_cnt registered, same edge as busy bits: +1 per 0->1 transition, -1 per 1->0 transition, net 0 if both occur or if reserving an already-busy register.
REQ-021 SHALL ignore a write to a non-busy register for busy_cnt (data still written).
REQ-022 SHALL never let busy_cnt exceed 2**ADDR_W or wrap below 0.

Reset
REQ-023 SHALL, while rst=1, clear all registers, all busy bits and busy_cnt to 0 asynchronously.
REQ-024 SHALL, while rst=1, block writes and reserves, suppress bypass, and drive src1=src2=0, src1_busy=src2_busy=0.
REQ-025 SHALL resume normal operation on the first rising clk after rst deasserts.

Configuration
REQ-026 SHALL honour macro REGFILE_ZERO_REG_EN: when defined, register 0 reads 0, writes to it are dropped, bypass is suppressed for address 0, reserves of it are ignored, its busy bit is constant 0.
REQ-027 SHALL, without REGFILE_ZERO_REG_EN, treat register 0 as an ordinary register.

Structure
REQ-028 SHALL take default DATA_W/ADDR_W constants from shared package regfile_pkg.
REQ-029 SHALL implement busy bits and busy_cnt in sub-module regfile_scoreboard; data array and bypass in regfile_sb.

Verification
REQ-030 SHALL fill reg k with 32'hAEAEAE00+k for k=0..31 then read srcadd1=6, srcadd2=28 -> src1=AEAEAE06, src2=AEAEAE1C (reg 0 reads 0 if REGFILE_ZERO_REG_EN).
REQ-031 SHALL cover bypass: wr_en=1, destadd=1, ALUout=44444444, srcadd2=1 same cycle -> src2=44444444 before the edge.
REQ-032 SHALL cover scoreboard: rsv 3, rsv 5 -> busy_cnt=2, src1_busy=1 at srcadd1=3; write 3 -> busy_cnt=1, src1_busy=0.
REQ-033 SHALL cover collision: rsv_add=destadd=7 same cycle, busy[7] previously 1 -> busy[7] stays 1, busy_cnt unchanged.
REQ-034 SHALL cover mid-operation reset: assert rst between edges with busy_cnt=4 -> busy_cnt=0, src1=src2=0 immediately, no clk required.
REQ-035 SHALL cover zero register with REGFILE_ZERO_REG_EN: write 0 with 33333333, rsv 0 -> src1=0 at srcadd1=0, busy_cnt unchanged.
